// File: rtl/flo_pkg.sv
// Shared types and widths for the flobuffer command dispatcher.
package flo_pkg;

    localparam int FLO_DATA_W  = 16;
    localparam int FLO_DELAY_W = 7;

    // Command payload. The channel index is kept beside it because its
    // width follows the dispatcher's N_CH parameter.
    typedef struct packed {
        logic [FLO_DELAY_W-1:0] delay;
        logic [FLO_DATA_W-1:0]  data;
        logic                   direct;
    } flo_cmd_t;

    // Occupancy of the single hold register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/flo_credit_ctr.sv
// Per-channel credit counter: one credit per free slot in the downstream
// buffer, with a sticky flag for pops that arrive while already full.
module flo_credit_ctr #(
    parameter int FIFO_SIZE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dec_i,     // timed command issued to this channel
    input  logic inc_i,     // buffer consumed one entry
    input  logic clear_i,   // clear sticky error
    output logic avail_o,   // at least one credit left
    output logic err_o      // sticky: pop seen with credits already full
);

    localparam int CW = $clog2(FIFO_SIZE + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_SIZE);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          sat_pop;

    // Next credit value; issue and pop together cancel out.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        cnt_d   = cnt_q;
        sat_pop = 1'b0;
        case ({dec_i, inc_i})
            2'b10:   cnt_d = cnt_q - ONE;
            2'b01: begin
                if (cnt_q == FULL) sat_pop = 1'b1;
                else               cnt_d   = cnt_q + ONE;
            end
            default: cnt_d = cnt_q;
        endcase
        // A new error in the same cycle as a clear wins.
        err_d = (err_q && !clear_i) || sat_pop;
    end

    // Credit and error state; full credit out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= FULL;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign avail_o = (cnt_q != '0);
    assign err_o   = err_q;

endmodule

// File: rtl/flo_dispatch.sv
// Command dispatcher: one hold register in front of a bank of flobuffers,
// issuing each command to its channel only when that channel has credit.
module flo_dispatch
    import flo_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int FIFO_SIZE = 2,
    localparam int CH_W     = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [CH_W-1:0]        cmd_ch_i,
    input  logic [FLO_DELAY_W-1:0] cmd_delay_i,
    input  logic [FLO_DATA_W-1:0]  cmd_data_i,
    input  logic                   cmd_direct_i,
    output logic [FLO_DATA_W-1:0]  buf_data_o,
    output logic [FLO_DELAY_W-1:0] buf_delay_o,
    output logic [N_CH-1:0]        buf_valid_o,
    output logic [N_CH-1:0]        buf_direct_o,
    input  logic [N_CH-1:0]        pop_i,
    input  logic [N_CH-1:0]        buf_err_i,
    output logic [N_CH-1:0]        err_o,
    output logic [N_CH-1:0]        credit_err_o,
    output logic                   stall_o
);

    hold_state_e            state_q;
    logic [CH_W-1:0]        hold_ch_q;
    flo_cmd_t               hold_q;

    logic [FLO_DATA_W-1:0]  buf_data_q;
    logic [FLO_DELAY_W-1:0] buf_delay_q;
    logic [N_CH-1:0]        buf_valid_q, buf_direct_q, err_q;

    logic [N_CH-1:0]        avail, dec, ch_onehot;
    logic                   hold_valid, issue, accept;

    assign hold_valid = (state_q == ST_HELD);
    assign ch_onehot  = N_CH'(1) << hold_ch_q;

    // Direct commands bypass credits; timed ones need a free slot.
    assign issue = hold_valid && enable_i && (hold_q.direct || avail[hold_ch_q]);

    // Gated by rst_n so the handshake stays closed while reset is asserted.
    assign cmd_ready_o = rst_n && enable_i && (!hold_valid || issue);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign stall_o     = hold_valid && !issue;

    assign dec = (issue && !hold_q.direct) ? ch_onehot : '0;

    // One credit counter per channel.
    for (genvar g = 0; g < N_CH; g++) begin : g_credit
        flo_credit_ctr #(.FIFO_SIZE(FIFO_SIZE)) u_ctr (
            .clk     (clk),
            .rst_n   (rst_n),
            .dec_i   (dec[g]),
            .inc_i   (pop_i[g]),
            .clear_i (clear_i),
            .avail_o (avail[g]),
            .err_o   (credit_err_o[g])
        );
    end

    // Hold-register FSM: load on accept, drain on issue without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            hold_ch_q <= '0;
            hold_q    <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept)            state_q <= ST_HELD;
                ST_HELD:  if (issue && !accept)  state_q <= ST_EMPTY;
                default:                         state_q <= ST_EMPTY;
            endcase
            if (accept) begin
                hold_ch_q     <= cmd_ch_i;
                hold_q.delay  <= cmd_delay_i;
                hold_q.data   <= cmd_data_i;
                hold_q.direct <= cmd_direct_i;
            end
        end
    end

    // Output steering: one-cycle strobe, buses keep the last issued fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_q   <= '0;
            buf_delay_q  <= '0;
            buf_valid_q  <= '0;
            buf_direct_q <= '0;
        end else begin
            buf_valid_q  <= (issue && !hold_q.direct) ? ch_onehot : '0;
            buf_direct_q <= (issue &&  hold_q.direct) ? ch_onehot : '0;
            if (issue) begin
                buf_data_q  <= hold_q.data;
                buf_delay_q <= hold_q.delay;
            end
        end
    end

    // Sticky buffer-overflow flags; a same-cycle set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= (err_q & ~{N_CH{clear_i}}) | buf_err_i;
    end

    assign buf_data_o   = buf_data_q;
    assign buf_delay_o  = buf_delay_q;
    assign buf_valid_o  = buf_valid_q;
    assign buf_direct_o = buf_direct_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_flo_dispatch.sv
// Self-checking bench for flo_dispatch: directed vector table, randomized
// traffic against a queue/array reference model, and reset corner cases.
module tb_flo_dispatch;

    localparam int FS = 2;

    logic        clk, rst_n;
    logic        enable_i, clear_i, cmd_valid_i, cmd_ready_o, cmd_direct_i;
    logic [2:0]  cmd_ch_i;
    logic [6:0]  cmd_delay_i, buf_delay_o;
    logic [15:0] cmd_data_i, buf_data_o;
    logic [7:0]  buf_valid_o, buf_direct_o, pop_i, buf_err_i, err_o, credit_err_o;
    logic        stall_o;

    flo_dispatch #(.N_CH(8), .FIFO_SIZE(FS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .clear_i      (clear_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_ch_i     (cmd_ch_i),
        .cmd_delay_i  (cmd_delay_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_direct_i (cmd_direct_i),
        .buf_data_o   (buf_data_o),
        .buf_delay_o  (buf_delay_o),
        .buf_valid_o  (buf_valid_o),
        .buf_direct_o (buf_direct_o),
        .pop_i        (pop_i),
        .buf_err_i    (buf_err_i),
        .err_o        (err_o),
        .credit_err_o (credit_err_o),
        .stall_o      (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en, clr, vld;
        logic [2:0] ch;
        logic [6:0] dly;
        logic [15:0] dat;
        logic       dir;
        logic [7:0] pop, berr;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        rdy, stl;
        logic [7:0]  bv, bd;
        logic [15:0] data;
        logic [6:0]  bdly;
        logic [7:0]  err, cerr;
    } vec_t;

    typedef struct packed {
        logic [2:0]  ch;
        logic [6:0]  dly;
        logic [15:0] dat;
        logic        dir;
    } mcmd_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    mcmd_t       hq[$];
    int          credit[8];
    logic        m_ready, m_stall;
    logic [7:0]  m_bv, m_bd, m_err, m_cerr;
    logic [15:0] m_data;
    logic [6:0]  m_dly;

    // Sampled combinational outputs of the most recent step
    logic        s_ready, s_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < 8; i++) credit[i] = FS;
        m_bv = '0; m_bd = '0; m_err = '0; m_cerr = '0; m_data = '0; m_dly = '0;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] bv, input logic [7:0] bd,
                              input logic [15:0] data, input logic [6:0] dly,
                              input logic [7:0] err, input logic [7:0] cerr);
        check({tag, ".buf_valid"},  32'(buf_valid_o),  32'(bv));
        check({tag, ".buf_direct"}, 32'(buf_direct_o), 32'(bd));
        check({tag, ".buf_data"},   32'(buf_data_o),   32'(data));
        check({tag, ".buf_delay"},  32'(buf_delay_o),  32'(dly));
        check({tag, ".err"},        32'(err_o),        32'(err));
        check({tag, ".credit_err"}, 32'(credit_err_o), 32'(cerr));
    endtask

    // One clock cycle: drive at negedge, check handshake, advance model at posedge.
    task automatic step(input stim_t s);
        logic       issue, acc;
        mcmd_t      h;
        logic [7:0] cset;
        @(negedge clk);
        enable_i = s.en;  clear_i = s.clr; cmd_valid_i = s.vld; cmd_ch_i = s.ch;
        cmd_delay_i = s.dly; cmd_data_i = s.dat; cmd_direct_i = s.dir;
        pop_i = s.pop; buf_err_i = s.berr;
        issue   = (hq.size() > 0) && s.en && (hq[0].dir || credit[hq[0].ch] > 0);
        m_ready = s.en && ((hq.size() == 0) || issue);
        m_stall = (hq.size() > 0) && !issue;
        acc     = s.vld && m_ready;
        #1;
        s_ready = cmd_ready_o;
        s_stall = stall_o;
        check("model.ready", 32'(s_ready), 32'(m_ready));
        check("model.stall", 32'(s_stall), 32'(m_stall));
        @(posedge clk);
        m_bv = '0; m_bd = '0; cset = '0;
        if (issue) begin
            h = hq.pop_front();
            m_data = h.dat;
            m_dly  = h.dly;
            if (h.dir) m_bd[h.ch] = 1'b1;
            else begin
                m_bv[h.ch] = 1'b1;
                credit[h.ch]--;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (s.pop[i]) begin
                if (credit[i] == FS) cset[i] = 1'b1;
                else                 credit[i]++;
            end
        end
        if (s.clr) begin
            m_err  = '0;
            m_cerr = '0;
        end
        m_err  = m_err | s.berr;
        m_cerr = m_cerr | cset;
        if (acc) hq.push_back('{s.ch, s.dly, s.dat, s.dir});
        #1;
        check_regs("model", m_bv, m_bd, m_data, m_dly, m_err, m_cerr);
    endtask

    // Assert reset mid-stream with enable high, then release.
    task automatic do_reset();
        @(negedge clk);
        enable_i = 1'b1; cmd_valid_i = 1'b1; rst_n = 1'b0;
        #1;
        check("rst.ready", 32'(cmd_ready_o), 32'd0);
        check("rst.stall", 32'(stall_o), 32'd0);
        check_regs("rst", 8'h00, 8'h00, 16'h0000, 7'h00, 8'h00, 8'h00);
        model_reset();
        @(negedge clk);
        cmd_valid_i = 1'b0; clear_i = 1'b0; pop_i = '0; buf_err_i = '0;
        rst_n = 1'b1;
        #1;
        check("rst.ready_after", 32'(cmd_ready_o), 32'd1);
    endtask

    function automatic vec_t mk(input logic en, input logic clr, input logic vld,
                                input logic [2:0] ch, input logic [6:0] dly,
                                input logic [15:0] dat, input logic dir,
                                input logic [7:0] pop, input logic [7:0] berr,
                                input logic rdy, input logic stl,
                                input logic [7:0] bv, input logic [7:0] bd,
                                input logic [15:0] data, input logic [6:0] bdly,
                                input logic [7:0] err, input logic [7:0] cerr);
        vec_t v;
        v.s = '{en, clr, vld, ch, dly, dat, dir, pop, berr};
        v.rdy = rdy; v.stl = stl; v.bv = bv; v.bd = bd;
        v.data = data; v.bdly = bdly; v.err = err; v.cerr = cerr;
        return v;
    endfunction

    vec_t tbl[29];

    initial begin
        stim_t rs;
        rst_n = 1'b0; enable_i = 1'b0; clear_i = 1'b0; cmd_valid_i = 1'b0;
        cmd_ch_i = '0; cmd_delay_i = '0; cmd_data_i = '0; cmd_direct_i = 1'b0;
        pop_i = '0; buf_err_i = '0;
        model_reset();

        //          en clr vld ch dly    dat      dir pop    berr  | rdy stl bv     bd     data     dly    err    cerr
        tbl[0]  = mk(1, 0, 1, 3, 7'd5,  16'hABCD, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h0000, 7'd0,  8'h00, 8'h00);
        tbl[1]  = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h08, 8'h00, 16'hABCD, 7'd5,  8'h00, 8'h00);
        tbl[2]  = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'hABCD, 7'd5,  8'h00, 8'h00);
        tbl[3]  = mk(1, 0, 1, 0, 7'd1,  16'h0001, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'hABCD, 7'd5,  8'h00, 8'h00);
        tbl[4]  = mk(1, 0, 1, 0, 7'd2,  16'h0002, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 16'h0001, 7'd1,  8'h00, 8'h00);
        tbl[5]  = mk(1, 0, 1, 0, 7'd3,  16'h0003, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 16'h0002, 7'd2,  8'h00, 8'h00);
        tbl[6]  = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 16'h0002, 7'd2,  8'h00, 8'h00);
        tbl[7]  = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h01, 8'h00, 0, 1, 8'h00, 8'h00, 16'h0002, 7'd2,  8'h00, 8'h00);
        tbl[8]  = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 16'h0003, 7'd3,  8'h00, 8'h00);
        tbl[9]  = mk(1, 0, 1, 0, 7'h11, 16'h1234, 1, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h0003, 7'd3,  8'h00, 8'h00);
        tbl[10] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h01, 16'h1234, 7'h11, 8'h00, 8'h00);
        tbl[11] = mk(1, 0, 1, 0, 7'd4,  16'h5555, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h1234, 7'h11, 8'h00, 8'h00);
        tbl[12] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 16'h1234, 7'h11, 8'h00, 8'h00);
        tbl[13] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h01, 8'h00, 0, 1, 8'h00, 8'h00, 16'h1234, 7'h11, 8'h00, 8'h00);
        tbl[14] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00, 16'h5555, 7'd4,  8'h00, 8'h00);
        tbl[15] = mk(1, 0, 1, 1, 7'd6,  16'h0B0B, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h5555, 7'd4,  8'h00, 8'h00);
        tbl[16] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h02, 8'h00, 1, 0, 8'h02, 8'h00, 16'h0B0B, 7'd6,  8'h00, 8'h00);
        tbl[17] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h04, 8'h00, 1, 0, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h00, 8'h04);
        tbl[18] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h20, 1, 0, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h20, 8'h04);
        tbl[19] = mk(1, 1, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h00, 8'h00);
        tbl[20] = mk(1, 1, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h01, 1, 0, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h01, 8'h00);
        tbl[21] = mk(1, 1, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h00, 8'h00);
        tbl[22] = mk(1, 0, 1, 4, 7'd9,  16'h7777, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h00, 8'h00);
        tbl[23] = mk(0, 0, 1, 5, 7'd2,  16'h9999, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h00, 8'h00);
        tbl[24] = mk(0, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 16'h0B0B, 7'd6,  8'h00, 8'h00);
        tbl[25] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 16'h7777, 7'd9,  8'h00, 8'h00);
        tbl[26] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h7777, 7'd9,  8'h00, 8'h00);
        tbl[27] = mk(1, 0, 0, 0, 7'd0,  16'h0000, 0, 8'h02, 8'h00, 1, 0, 8'h00, 8'h00, 16'h7777, 7'd9,  8'h00, 8'h02);
        tbl[28] = mk(1, 1, 0, 0, 7'd0,  16'h0000, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 16'h7777, 7'd9,  8'h00, 8'h00);

        repeat (2) @(negedge clk);
        do_reset();

        // Directed vectors
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].s);
            check($sformatf("vec%0d.ready", i), 32'(s_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d.stall", i), 32'(s_stall), 32'(tbl[i].stl));
            check_regs($sformatf("vec%0d", i), tbl[i].bv, tbl[i].bd, tbl[i].data,
                       tbl[i].bdly, tbl[i].err, tbl[i].cerr);
        end

        // Mid-stream reset with a command held and ch 0 drained, then check full credit returns
        step('{1'b1, 1'b0, 1'b1, 3'd0, 7'd1, 16'h00A1, 1'b0, 8'h00, 8'h00});
        step('{1'b1, 1'b0, 1'b1, 3'd0, 7'd2, 16'h00A2, 1'b0, 8'h00, 8'h00});
        step('{1'b1, 1'b0, 1'b1, 3'd0, 7'd3, 16'h00A3, 1'b0, 8'h00, 8'h00});
        do_reset();
        step('{1'b1, 1'b0, 1'b1, 3'd0, 7'd4, 16'h00B1, 1'b0, 8'h00, 8'h00});
        step('{1'b1, 1'b0, 1'b1, 3'd0, 7'd5, 16'h00B2, 1'b0, 8'h00, 8'h00});
        step('{1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 16'h0000, 1'b0, 8'h00, 8'h00});
        check("post_rst.second_strobe", 32'(buf_valid_o), 32'h01);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            rs.en   = ($urandom % 10) != 0;
            rs.clr  = ($urandom % 20) == 0;
            rs.vld  = ($urandom % 10) < 7;
            rs.ch   = ($urandom % 2) ? 3'($urandom % 2) : 3'($urandom);
            rs.dly  = 7'($urandom);
            rs.dat  = 16'($urandom);
            rs.dir  = ($urandom % 5) == 0;
            for (int i = 0; i < 8; i++) begin
                rs.pop[i]  = ((credit[i] < FS) && ($urandom % 3 == 0)) || ($urandom % 64 == 0);
                rs.berr[i] = ($urandom % 64) == 0;
            end
            step(rs);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
